// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
// Build option: UART_RX_PARITY_EN adds the PARITY receive state.
package uart_pkg;

  // Oversampling rate: baud ticks per bit period.
  localparam int OVS_RATE = 16;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,PARITY = 3'd4
`endif
  } uartState_e;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] count_q, count_d;
  logic         wrap;

  assign wrap   = (count_q == W'(DIV - 1));
  assign tick_o = wrap;

  // Next count: wrap back to zero after the terminal value.
  always_comb begin
    count_d = count_q + W'(1);
    if (wrap) begin
      count_d = '0;
    end
  end

  // Counter register; never stops, so tick phase is independent of the line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, 16x oversampled, valid/ready output handshake.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with parity_err_o;
// without it frames are 8N1 and that port does not exist.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       UART_RXD,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       busy_o
);

  localparam int OVS_DIV = CLK_HZ / (OVS_RATE * BAUD);

  if (OVS_DIV < 2) begin : gen_div_check
    $error("uart_rx: CLK_HZ/(16*BAUD) must be at least 2");
  end

  logic       tick;
  logic       rxMeta_q, rxSync_q, rxPrev_q;
  logic       fallEdge;
  uartState_e state_q, state_d;
  logic [3:0] sampleCnt_q, sampleCnt_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] shiftReg_q, shiftReg_d;
  logic       deliver, frameErr;
  logic [7:0] rxData_q;
  logic       rxValid_q, frameErr_q, overrun_q;
`ifdef UART_RX_PARITY_EN
  logic       parityBad_q, parityBad_d;
  logic       parityErr, parityErr_q;
`endif

  uart_baud_tick #(
    .DIV (OVS_DIV)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // Two-flop synchronizer plus one history flop; all reset high so the idle line shows no edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= UART_RXD;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // Only a real 1->0 transition starts a frame, so a held-low break cannot retrigger.
  assign fallEdge = rxPrev_q & ~rxSync_q;

  // Frame sequencing: start qualified at half a bit, then one sample per 16 ticks.
  always_comb begin
    state_d     = state_q;
    sampleCnt_d = sampleCnt_q;
    bitIdx_d    = bitIdx_q;
    shiftReg_d  = shiftReg_q;
    deliver     = 1'b0;
    frameErr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBad_d = parityBad_q;
    parityErr   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (fallEdge) begin
          state_d     = START;
          sampleCnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sampleCnt_q == 4'd7) begin
            sampleCnt_d = '0;
            bitIdx_d    = '0;
            state_d     = rxSync_q ? IDLE : DATA;
          end else begin
            sampleCnt_d = sampleCnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sampleCnt_d = sampleCnt_q + 4'd1;
          if (sampleCnt_q == 4'd15) begin
            shiftReg_d = {rxSync_q, shiftReg_q[7:1]};
            bitIdx_d   = bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          sampleCnt_d = sampleCnt_q + 4'd1;
          if (sampleCnt_q == 4'd15) begin
            parityBad_d = rxSync_q ^ (^shiftReg_q);
            state_d     = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          sampleCnt_d = sampleCnt_q + 4'd1;
          if (sampleCnt_q == 4'd15) begin
            state_d = IDLE;
            if (!rxSync_q) begin
              frameErr = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (parityBad_q) begin
              parityErr = 1'b1;
`endif
            end else begin
              deliver = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and frame-assembly registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sampleCnt_q <= '0;
      bitIdx_q    <= '0;
      shiftReg_q  <= '0;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sampleCnt_q <= sampleCnt_d;
      bitIdx_q    <= bitIdx_d;
      shiftReg_q  <= shiftReg_d;
`ifdef UART_RX_PARITY_EN
      parityBad_q <= parityBad_d;
`endif
    end
  end

  // Output holding register: a new byte is dropped if the old one is still waiting
  // and not being taken this cycle; a byte taken in the same cycle is simply replaced.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      frameErr_q <= frameErr;
      overrun_q  <= 1'b0;
      if (deliver) begin
        if (rxValid_q && !rx_ready_i) begin
          overrun_q <= 1'b1;
        end else begin
          rxData_q  <= shiftReg_q;
          rxValid_q <= 1'b1;
        end
      end else if (rxValid_q && rx_ready_i) begin
        rxValid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse, aligned with where delivery would have happened.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      parityErr_q <= 1'b0;
    end else begin
      parityErr_q <= parityErr;
    end
  end

  assign parity_err_o = parityErr_q;
`endif

  assign rx_data_o   = rxData_q;
  assign rx_valid_o  = rxValid_q;
  assign frame_err_o = frameErr_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a behavioural receiver model.
// The model predicts, per frame, which event must appear around the stop-bit mid-point
// and tracks the output holding register (valid/data) with the handshake rules.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BAUD     = 115200;
  localparam int OVS_DIV  = 4;
  localparam int CLK_HZ   = OVS_DIV * 16 * BAUD;
  localparam int BIT_CLKS = OVS_DIV * 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Stop bit sampled half a bit into it, after the 2-cycle synchronizer.
  localparam int STOP_MID = 2 + (FRAME_BITS - 1) * BIT_CLKS + BIT_CLKS / 2;

  typedef enum {EV_GOOD, EV_FRAME, EV_PARITY} evKind_e;
  typedef struct {
    evKind_e    kind;
    logic [7:0] data;
    int         lo;
    int         hi;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rxReady;
  logic [7:0] rxData;
  logic       rxValid;
  logic       frameErr;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parityErr;
  int         parErrCnt = 0;
`endif

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         expBusy;
  ev_t        expQ[$];
  logic       modelValid = 1'b0;
  logic [7:0] modelData = 8'h00;

  int         frameErrCnt = 0;
  int         overrunCnt = 0;
  int         validRiseCnt = 0;
  int         validHighCnt = 0;
  int         lastRiseCyc = 0;
  logic [7:0] lastRiseData = 8'h00;
  logic       validPrev = 1'b0;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .UART_RXD     (rxd),
    .rx_data_o    (rxData),
    .rx_valid_o   (rxValid),
    .rx_ready_i   (rxReady),
    .frame_err_o  (frameErr),
    .overrun_o    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err_o (parityErr),
`endif
    .busy_o       (busy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Cycle counter used to place each frame's event window.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame LSB first and register the event the model expects from it.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parBit,
                               input logic ready, output int fallCyc);
    ev_t ev;
    rxReady = ready;
    fallCyc = cyc;
    ev.data = data;
    ev.kind = stopBit ? EV_GOOD : EV_FRAME;
`ifdef UART_RX_PARITY_EN
    if (stopBit && (parBit != ^data)) ev.kind = EV_PARITY;
`endif
    ev.lo = cyc + STOP_MID - 10;
    ev.hi = cyc + STOP_MID + 10;
    expQ.push_back(ev);
    rxd = 1'b0;
    expBusy = -1;
    waitCycles(4);
    expBusy = 1;
    waitCycles(BIT_CLKS - 4);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      waitCycles(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rxd = parBit;
    waitCycles(BIT_CLKS);
`endif
    rxd = stopBit;
    waitCycles(20);
    expBusy = -1;
    waitCycles(BIT_CLKS - 20);
    expBusy = 0;
  endtask

  // Short low pulse on an idle line: must be rejected at the start-bit mid-point.
  task automatic applyGlitch(input int lowClks);
    rxd = 1'b0;
    expBusy = -1;
    waitCycles(4);
    expBusy = 1;
    waitCycles(lowClks - 4);
    rxd = 1'b1;
    waitCycles(28 - lowClks);
    expBusy = -1;
    waitCycles(20);
    expBusy = 0;
  endtask

  // Pulse and delivery counters for the directed checks.
  always @(negedge clk) begin
    if (frameErr) frameErrCnt++;
    if (overrun) overrunCnt++;
`ifdef UART_RX_PARITY_EN
    if (parityErr) parErrCnt++;
`endif
    if (rxValid) validHighCnt++;
    if (rxValid && !validPrev) begin
      validRiseCnt++;
      lastRiseData = rxData;
      lastRiseCyc = cyc;
    end
    validPrev = rxValid;
  end

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    ev_t  ev;
    logic expFrame, expOver, observed;
`ifdef UART_RX_PARITY_EN
    logic expPar;
    expPar = 1'b0;
`endif
    expFrame = 1'b0;
    expOver  = 1'b0;
    if (rst) begin
      expQ.delete();
      modelValid = 1'b0;
      modelData  = 8'h00;
      checkOutput("reset rx_valid", rxValid, 0);
      checkOutput("reset rx_data", rxData, 0);
      checkOutput("reset frame_err", frameErr, 0);
      checkOutput("reset overrun", overrun, 0);
      checkOutput("reset busy", busy, 0);
    end else begin
      if (expQ.size() > 0 && cyc > expQ[0].hi) begin
        checkOutput("frame event seen in window", 0, 1);
        void'(expQ.pop_front());
      end
      observed = frameErr || overrun || (rxValid && (!modelValid || rxData != modelData));
`ifdef UART_RX_PARITY_EN
      observed = observed || parityErr;
`endif
      if (expQ.size() > 0 && cyc >= expQ[0].lo && observed) begin
        ev = expQ.pop_front();
        case (ev.kind)
          EV_GOOD: begin
            if (modelValid && !rxReady) expOver = 1'b1;
            else begin
              modelValid = 1'b1;
              modelData  = ev.data;
            end
          end
          EV_FRAME: expFrame = 1'b1;
          EV_PARITY: begin
`ifdef UART_RX_PARITY_EN
            expPar = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      checkOutput("rx_valid", rxValid, modelValid);
      if (modelValid) checkOutput("rx_data", rxData, modelData);
      checkOutput("frame_err", frameErr, expFrame);
      checkOutput("overrun", overrun, expOver);
`ifdef UART_RX_PARITY_EN
      checkOutput("parity_err", parityErr, expPar);
`endif
      if (expBusy >= 0) checkOutput("busy", busy, expBusy);
      if (modelValid && rxReady) modelValid = 1'b0;
    end
  end

  initial begin
    int         c0;
    int         lat;
    int         rises0, high0, ferr0, ovr0;
    int         sel;
    logic [7:0] d;
    logic       rdy, parB;

    rst = 1'b1;
    rxd = 1'b1;
    rxReady = 1'b0;
    expBusy = 0;
    waitCycles(5);
    checkOutput("reset literal rx_valid", rxValid, 0);
    checkOutput("reset literal busy", busy, 0);
    rst = 1'b0;
    waitCycles(10);

    // 0xA5, consumer always ready.
    $display("[TB] frame 0xA5");
    rises0 = validRiseCnt; high0 = validHighCnt; ferr0 = frameErrCnt; ovr0 = overrunCnt;
    applyStimulus(8'hA5, 1'b1, ^8'hA5, 1'b1, c0);
    rxd = 1'b1;
    waitCycles(BIT_CLKS);
    lat = lastRiseCyc - c0;
    checkOutput("A5 delivered once", validRiseCnt - rises0, 1);
    checkOutput("A5 data", lastRiseData, 8'hA5);
    checkOutput("A5 valid one cycle", validHighCnt - high0, 1);
    checkOutput("A5 latency near stop mid-bit", (lat >= STOP_MID - 4 && lat <= STOP_MID + 4), 1);
    checkOutput("A5 no errors", (frameErrCnt - ferr0) + (overrunCnt - ovr0), 0);

    // 20-clock glitch on the idle line.
    $display("[TB] glitch");
    rises0 = validRiseCnt; ferr0 = frameErrCnt;
    applyGlitch(20);
    waitCycles(BIT_CLKS);
    checkOutput("glitch no delivery", validRiseCnt - rises0, 0);
    checkOutput("glitch no frame error", frameErrCnt - ferr0, 0);
    checkOutput("glitch busy back low", busy, 0);

    // Bad stop bit followed by a 10-bit break, then a good frame.
    $display("[TB] frame error and break");
    rises0 = validRiseCnt; ferr0 = frameErrCnt;
    applyStimulus(8'h3C, 1'b0, ^8'h3C, 1'b1, c0);
    waitCycles(10 * BIT_CLKS);
    checkOutput("break one frame error", frameErrCnt - ferr0, 1);
    checkOutput("break no delivery", validRiseCnt - rises0, 0);
    checkOutput("break busy low", busy, 0);
    rxd = 1'b1;
    waitCycles(2 * BIT_CLKS);
    applyStimulus(8'h5A, 1'b1, ^8'h5A, 1'b1, c0);
    rxd = 1'b1;
    waitCycles(BIT_CLKS);
    checkOutput("after break delivered", validRiseCnt - rises0, 1);
    checkOutput("after break data", lastRiseData, 8'h5A);

    // Overrun: two bytes without the consumer ready.
    $display("[TB] overrun");
    ovr0 = overrunCnt;
    applyStimulus(8'h11, 1'b1, ^8'h11, 1'b0, c0);
    rxd = 1'b1;
    waitCycles(BIT_CLKS);
    applyStimulus(8'h22, 1'b1, ^8'h22, 1'b0, c0);
    rxd = 1'b1;
    waitCycles(BIT_CLKS);
    checkOutput("overrun keeps old data", rxData, 8'h11);
    checkOutput("overrun valid held", rxValid, 1);
    checkOutput("overrun one pulse", overrunCnt - ovr0, 1);
    rxReady = 1'b1;
    @(negedge clk);
    checkOutput("valid during accept", rxValid, 1);
    @(negedge clk);
    checkOutput("valid cleared after accept", rxValid, 0);
    waitCycles(BIT_CLKS);

    // Reset in the middle of 0x7E (bit 4 is high), then 0x81.
    $display("[TB] reset mid-frame");
    applyStimulus(8'h6B, 1'b1, ^8'h6B, 1'b0, c0);
    rxd = 1'b1;
    waitCycles(BIT_CLKS);
    rises0 = validRiseCnt; ferr0 = frameErrCnt; ovr0 = overrunCnt;
    rxd = 1'b0;
    expBusy = -1;
    waitCycles(4);
    expBusy = 1;
    waitCycles(BIT_CLKS - 4);
    d = 8'h7E;
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      waitCycles(BIT_CLKS);
    end
    rxd = d[4];
    waitCycles(BIT_CLKS / 2);
    rst = 1'b1;
    expBusy = -1;
    waitCycles(8);
    checkOutput("reset drops held byte", rxValid, 0);
    rst = 1'b0;
    expBusy = 0;
    waitCycles(2 * BIT_CLKS);
    applyStimulus(8'h81, 1'b1, ^8'h81, 1'b1, c0);
    rxd = 1'b1;
    waitCycles(BIT_CLKS);
    checkOutput("after reset one delivery", validRiseCnt - rises0, 1);
    checkOutput("after reset data", lastRiseData, 8'h81);
    checkOutput("after reset no pulses", (frameErrCnt - ferr0) + (overrunCnt - ovr0), 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 1 is even, 0 is an error.
    $display("[TB] parity");
    rises0 = validRiseCnt;
    ferr0 = parErrCnt;
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1, c0);
    rxd = 1'b1;
    waitCycles(BIT_CLKS);
    checkOutput("bad parity one pulse", parErrCnt - ferr0, 1);
    checkOutput("bad parity no delivery", validRiseCnt - rises0, 0);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1, c0);
    rxd = 1'b1;
    waitCycles(BIT_CLKS);
    checkOutput("good parity delivered", validRiseCnt - rises0, 1);
    checkOutput("good parity data", lastRiseData, 8'h07);
`endif

    // Randomized traffic: good frames, bad stop bits, glitches, random consumer.
    $display("[TB] random frames");
    for (int n = 0; n < 14; n++) begin
      sel  = int'($urandom_range(0, 9));
      d    = 8'($urandom);
      rdy  = 1'($urandom_range(0, 1));
      parB = ^d;
      if ($urandom_range(0, 5) == 0) parB = ~parB;
      if (sel == 0) applyGlitch(int'($urandom_range(8, 20)));
      else applyStimulus(d, (sel != 1), parB, rdy, c0);
      rxd = 1'b1;
      waitCycles(BIT_CLKS * int'($urandom_range(1, 3)));
    end

    waitCycles(200);
    checkOutput("all expected events seen", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
